alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare helper. It accepts one operation at a time over a valid/ready handshake and grants requesters round-robin. It registers the operands, drives the ALU for one cycle, and captures the result. The result is returned to the granted requester over a valid/ready response handshake.

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between the execute
// stage (port 0) and the address/branch-compare helper (port 1).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_src1_0,
  input  logic [WIDTH-1:0] req_src1_1,
  input  logic [WIDTH-1:0] req_src2_0,
  input  logic [WIDTH-1:0] req_src2_1,
  input  logic [4:0]       req_shamt_0,
  input  logic [4:0]       req_shamt_1,
  input  logic [5:0]       req_funct_0,
  input  logic [5:0]       req_funct_1,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [4:0]       alu_shamt,
  output logic [5:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             ptr_reg;
  logic             id_reg;
  logic [WIDTH-1:0] src1_reg;
  logic [WIDTH-1:0] src2_reg;
  logic [4:0]       shamt_reg;
  logic [5:0]       funct_reg;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg;
  logic [1:0]       rsp_valid_reg;

  logic             grant_id;
  logic             take;
  logic [WIDTH-1:0] sel_src1;
  logic [WIDTH-1:0] sel_src2;
  logic [4:0]       sel_shamt;
  logic [5:0]       sel_funct;
  logic             funct_ok;

  // The pointer's requester wins if it is asking; otherwise the other one gets it.
  assign grant_id = req_valid[ptr_reg] ? ptr_reg : ~ptr_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant_id == 1'(gi));
    end
  endgenerate

  assign take = |req_ready;

  always_comb begin
    sel_src1  = req_src1_0;
    sel_src2  = req_src2_0;
    sel_shamt = req_shamt_0;
    sel_funct = req_funct_0;
    if (grant_id) begin
      sel_src1  = req_src1_1;
      sel_src2  = req_src2_1;
      sel_shamt = req_shamt_1;
      sel_funct = req_funct_1;
    end
  end

  always_comb begin
    case (funct_reg)
      6'b001001, 6'b010010, 6'b001010, 6'b010011, 6'b101010: funct_ok = 1'b1;
      default:                                               funct_ok = 1'b0;
    endcase
  end

  // Operand registers double as the ALU drive, so the ALU inputs stay stable
  // through EXEC and RESP and keep the last operation while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      src1_reg      <= '0;
      src2_reg      <= '0;
      shamt_reg     <= '0;
      funct_reg     <= '0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take) begin
            src1_reg  <= sel_src1;
            src2_reg  <= sel_src2;
            shamt_reg <= sel_shamt;
            funct_reg <= sel_funct;
            id_reg    <= grant_id;
            ptr_reg   <= ~grant_id;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg    <= funct_ok ? alu_result : '0;
          err_reg       <= ~funct_ok;
          rsp_valid_reg <= id_reg ? 2'b10 : 2'b01;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready[id_reg]) begin
            rsp_valid_reg <= 2'b00;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 2'b00;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign alu_src1   = src1_reg;
  assign alu_src2   = src2_reg;
  assign alu_shamt  = shamt_reg;
  assign alu_funct  = funct_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = result_reg;
  assign rsp_err    = err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU sits on the alu_* side and
// every step compares DUT outputs against hand-computed values.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_src1_0, req_src1_1, req_src2_0, req_src2_1;
  logic [4:0]  req_shamt_0, req_shamt_1;
  logic [5:0]  req_funct_0, req_funct_1;
  logic [31:0] alu_src1, alu_src2;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1_0(req_src1_0), .req_src1_1(req_src1_1),
    .req_src2_0(req_src2_0), .req_src2_1(req_src2_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .req_funct_0(req_funct_0), .req_funct_1(req_funct_1),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; unsupported codes return junk that the DUT must suppress.
  always_comb begin
    case (alu_funct)
      6'b001001:            alu_result = alu_src1 + alu_src2;
      6'b010010, 6'b001010: alu_result = alu_src1 - alu_src2;
      6'b010011:            alu_result = ~(alu_src1 | alu_src2);
      6'b101010:            alu_result = {31'd0, alu_src1 < alu_src2};
      default:              alu_result = 32'hDEADBEEF ^ {27'd0, alu_shamt};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_src1_0 = '0; req_src1_1 = '0; req_src2_0 = '0; req_src2_1 = '0;
    req_shamt_0 = '0; req_shamt_1 = '0; req_funct_0 = '0; req_funct_1 = '0;

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_src1", alu_src1, 32'd0);
    chk("rst_alu_funct", 32'(alu_funct), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    // Single addu from requester 0: 5 + 3
    req_src1_0 = 32'd5; req_src2_0 = 32'd3; req_shamt_0 = 5'd3; req_funct_0 = 6'b001001;
    req_valid = 2'b01;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    step();
    req_valid = 2'b00;
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_alu_src1", alu_src1, 32'd5);
    chk("t1_alu_src2", alu_src2, 32'd3);
    chk("t1_alu_shamt", 32'(alu_shamt), 32'd3);
    chk("t1_alu_funct", 32'(alu_funct), 32'h09);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_result", rsp_result, 32'd8);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_alu_retained", alu_src1, 32'd5);

    // Both valid, pointer 0: subu 10-3 then sltu 2<7
    pulse_reset();
    req_src1_0 = 32'd10; req_src2_0 = 32'd3; req_shamt_0 = 5'd0; req_funct_0 = 6'b010010;
    req_src1_1 = 32'd2;  req_src2_1 = 32'd7; req_shamt_1 = 5'd0; req_funct_1 = 6'b101010;
    req_valid = 2'b11;
    #1;
    chk("t2_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b10;
    chk("t2_exec_no_ready", 32'(req_ready), 32'd0);
    step();
    chk("t2_rsp0_valid", 32'(rsp_valid), 32'h1);
    chk("t2_rsp0_result", rsp_result, 32'd7);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("t2_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    step();
    chk("t2_rsp1_valid", 32'(rsp_valid), 32'h2);
    chk("t2_rsp1_result", rsp_result, 32'd1);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;

    // Next pair starts at requester 0; requester 1 does a nor
    req_src1_0 = 32'd100; req_src2_0 = 32'd23; req_funct_0 = 6'b001001;
    req_src1_1 = 32'h0000FFFF; req_src2_1 = 32'h00FF0000; req_funct_1 = 6'b010011;
    req_valid = 2'b11;
    #1;
    chk("t3_grant0_first", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b10;
    step();
    chk("t3_rsp0_result", rsp_result, 32'd123);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("t3_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    step();
    chk("t3_nor_valid", 32'(rsp_valid), 32'h2);
    chk("t3_nor_result", rsp_result, 32'hFF000000);
    chk("t3_nor_err", 32'(rsp_err), 32'd0);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;

    // Unsupported funct: error flag, result forced to zero
    req_src1_0 = 32'd4; req_src2_0 = 32'd5; req_funct_0 = 6'b000000;
    req_valid = 2'b01;
    #1;
    chk("t4_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_err", 32'(rsp_err), 32'd1);
    chk("t4_rsp_result", rsp_result, 32'd0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("t4_back_idle", 32'(busy), 32'd0);

    // Pointer now 1: requester 1 addu held in RESP for 5 cycles
    req_src1_1 = 32'd1; req_src2_1 = 32'd1; req_funct_1 = 6'b001001;
    req_src1_0 = 32'd20; req_src2_0 = 32'd5; req_funct_0 = 6'b001010;
    req_valid = 2'b11;
    #1;
    chk("t5_grant1", 32'(req_ready), 32'h2);
    step();
    step();
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(rsp_valid), 32'h2);
      chk("t5_hold_result", rsp_result, 32'd2);
      chk("t5_hold_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    chk("t5_release_idle", 32'(busy), 32'd0);
    chk("t5_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();
    chk("t5_subu_alt_valid", 32'(rsp_valid), 32'h1);
    chk("t5_subu_alt_result", rsp_result, 32'd15);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;

    // Reset during EXEC aborts everything
    req_src1_0 = 32'd7; req_src2_0 = 32'd8; req_funct_0 = 6'b001001;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("t6_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_rsp_result", rsp_result, 32'd0);
    chk("t6_rst_alu_src1", alu_src1, 32'd0);
    chk("t6_rst_alu_funct", 32'(alu_funct), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("t6_no_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("t6_ptr_zero", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();
    chk("t6_after_rsp_result", rsp_result, 32'd15);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
